// File: rtl/leg_pkg.sv
// Shared types and widths for the LEG CPU front end.
package leg_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_REG    = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Instruction addresses are always word aligned.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/leg_fetch_next_pc.sv
// Next-PC selection for the fetch stage: hold, increment, register target or
// PC-relative branch, always word aligned.
module leg_fetch_next_pc
  import leg_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] k,
  input  logic [ADDR_W-1:0] reg_a,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  logic [ADDR_W-1:0] rel_off;
  logic [ADDR_W-1:0] target;

  assign pc_plus4 = pc + ADDR_W'(4);
  // k is a word offset; control always pairs a branch with pc_src=1.
  assign rel_off  = pc_src ? (k << 2) : ADDR_W'(4);

  always_comb begin
    target = pc;
    case (pc_sel_e'(pc_sel))
      PC_HOLD:   target = pc;
      PC_INC:    target = pc_plus4;
      PC_REG:    target = reg_a;
      PC_BRANCH: target = pc + rel_off;
      default:   target = pc;
    endcase
  end

  assign next_pc = align_word(target);

endmodule

// File: rtl/leg_fetch_unit.sv
// LEG instruction fetch stage: owns the PC, issues imem requests and holds the
// fetched word until control retires it. LEG_FETCH_PREFETCH_EN adds a prefetch buffer.
module leg_fetch_unit
  import leg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  k,
  input  logic [ADDR_W-1:0]  reg_a,
  input  logic               instr_ready,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4
);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_reg;
  logic               pend_reg;
  logic               retire, rsp, pend_after, seq_retire;
  logic               pf_issue, pf_hit;
  logic [INSTR_W-1:0] hit_data;

  leg_fetch_next_pc u_next_pc (
    .pc       (pc_reg),
    .pc_sel   (pc_sel),
    .pc_src   (pc_src),
    .k        (k),
    .reg_a    (reg_a),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  assign retire     = (state_reg == HOLD) && instr_ready;
  assign seq_retire = retire && (pc_sel_e'(pc_sel) == PC_INC);
  assign rsp        = pend_reg && imem_valid;
  assign pend_after = pend_reg && !imem_valid;

`ifdef LEG_FETCH_PREFETCH_EN
  logic               pf_full_reg;
  logic [INSTR_W-1:0] pf_data_reg;

  assign pf_issue = !rst && (state_reg == HOLD) && !pend_reg && !pf_full_reg && !instr_ready;
  // A prefetch response landing in the retire cycle counts as a buffer hit.
  assign pf_hit   = pf_full_reg || ((state_reg == HOLD) && rsp);
  assign hit_data = pf_full_reg ? pf_data_reg : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_full_reg <= 1'b0;
      pf_data_reg <= '0;
    end else if (retire) begin
      pf_full_reg <= 1'b0;
    end else if ((state_reg == HOLD) && rsp) begin
      pf_full_reg <= 1'b1;
      pf_data_reg <= imem_rdata;
    end
  end
`else
  assign pf_issue = 1'b0;
  assign pf_hit   = 1'b0;
  assign hit_data = imem_rdata;
`endif

  // The outstanding flag deliberately ignores rst so a stale response is drained.
  always_ff @(posedge clk) begin
    pend_reg <= pend_after || imem_req;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= pend_after ? DRAIN : FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: state_next = WAIT;
      WAIT:  if (rsp) state_next = HOLD;
      HOLD: begin
        if (retire) begin
          if (seq_retire && pf_hit)          state_next = HOLD;
          else if (seq_retire && pend_after) state_next = WAIT;
          else if (pend_after)               state_next = DRAIN;
          else                               state_next = FETCH;
        end
      end
      DRAIN: if (rsp) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_reg;
    instr_valid = (state_reg == HOLD);
    if (!rst && ((state_reg == FETCH) || pf_issue)) imem_req = 1'b1;
    if (pf_issue) imem_addr = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
    end else begin
      if ((state_reg == WAIT) && rsp) instr_reg <= imem_rdata;
      if (retire) begin
        pc_reg <= next_pc;
        if (seq_retire && pf_hit) instr_reg <= hit_data;
      end
    end
  end

  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: doc/leg_fetch_unit.md
# leg_fetch_unit

Instruction-fetch stage of the LEG multi-cycle CPU. It sits directly upstream of the control unit. It owns the program counter and issues instruction-memory requests. It holds the fetched word stable for control until control retires it. On retirement it applies control's PC-select, PC-source and K outputs to form the next PC.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_sel` in 2: from control word; 0 hold, 1 increment, 2 register, 3 branch.
- `pc_src` in 1: from control word; 1 selects the PC-relative offset; with pc_sel=3 it must be 1.
- `k` in 64: from control; signed word offset, already sign-extended.
- `reg_a` in 64: register-file read port A; the target for BR.
- `instr_ready` in 1: control retires the current instruction; sampled only while `instr_valid`=1.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 64: request address; valid when `imem_req`=1.
- `imem_valid` in 1: response strobe; arrives ≥1 cycle after its request; memory is in-order.
- `imem_rdata` in 32: response data; valid with `imem_valid`.
- `instr` out 32: instruction to control; stable while `instr_valid`=1.
- `instr_valid` out 1: `instr` holds a fetched word.
- `pc` out 64: address of `instr`.
- `pc_plus4` out 64: `pc`+4; the link value for BL.

## Operation
- FSM states: FETCH, WAIT, HOLD, DRAIN.
- FETCH: drive `imem_req`=1 with `imem_addr`=`pc` for one cycle, then go to WAIT.
- WAIT: on `imem_valid`, capture `imem_rdata` into `instr` and go to HOLD.
- HOLD: `instr_valid`=1. When `instr_ready`=1, compute the next PC, then go to FETCH, or to DRAIN if a discarded response is still outstanding.
- DRAIN: swallow exactly one `imem_valid`, then go to FETCH.
- Next PC, all arithmetic mod 2^64:
  - pc_sel 0: `pc` (refetch).
  - pc_sel 1: `pc`+4.
  - pc_sel 2: `reg_a`.
  - pc_sel 3: `pc` + (`k` << 2).
- The next PC always has bits [1:0] forced to 0.
- Exactly one request is outstanding at a time, including the prefetch request.
- `imem_valid` outside WAIT/DRAIN (or the prefetch window) is ignored.
- Reset values: `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_req`=0, `instr`=0, `instr_valid`=0, state=FETCH.
- If a request is outstanding at reset, a drop flag survives reset. The first post-reset state is then DRAIN, so the stale response never reaches `instr`.

## Timing
- Best-case fetch latency:
  - `imem_req` at cycle t;
  - `imem_valid` at t+1;
  - `instr_valid` rises at t+2.
- `instr_ready` asserted in cycle h causes:
  - `instr_valid`=0 and the new `pc` at h+1;
  - `imem_req` at h+1.
- `instr_ready` together with `rst`: reset wins.
- `instr_ready` while `instr_valid`=0 has no effect.
- `pc_plus4` is combinational from `pc`.

## Configuration
- `LEG_FETCH_PREFETCH_EN` defined: adds a one-entry sequential prefetch buffer.
  - In HOLD with no request outstanding and the buffer empty, issue a request for `pc`+4 and capture the response into the buffer.
  - Retire with pc_sel=1 and the buffer full: `instr` loads from the buffer, and `instr_valid` is high at h+1 (no FETCH).
  - Retire with pc_sel=1 and the prefetch outstanding: go to WAIT and accept that response.
  - Any other pc_sel: invalidate the buffer. If the prefetch is outstanding, go to DRAIN; otherwise go to FETCH.
- `LEG_FETCH_PREFETCH_EN` undefined: no buffer, no requests in HOLD; behaviour is exactly as in Operation.

## Structure
- Shared package `leg_pkg`:
  - `pc_sel_e` (PC_HOLD=0, PC_INC=1, PC_REG=2, PC_BRANCH=3);
  - `fetch_state_e`;
  - `INSTR_W`=32, `ADDR_W`=64.
- Sub-module `leg_fetch_next_pc`: combinational next-PC mux, adder and alignment.
- The FSM, PC register, instruction register and prefetch buffer stay in `leg_fetch_unit`.

## Test plan
- Reset, then memory returns 32'h91000421 one cycle after the request → `imem_addr`=0, `instr_valid` high at cycle 2 with `pc`=0.
- Retire with pc_sel=1, then pc_sel=3 with `k`=-2 at `pc`=8 → next `pc`=12, then 4.
- pc_sel=2 with `reg_a`=64'h103 → `pc`=64'h100; pc_sel=0 → same `pc` refetched.
- Branch at `pc`=0 with `k`=-1 → `pc`=64'hFFFF_FFFF_FFFF_FFFC (wrap).
- `rst` while WAIT with the response arriving 3 cycles later → response discarded, first `instr` comes from `RESET_PC`.
- `LEG_FETCH_PREFETCH_EN`:
  - sequential retire with a full buffer → `instr_valid` at h+1, no extra `imem_req`;
  - branch retire → buffer dropped and `instr` comes from the target.
